// File: rtl/c_regresivo_mmss.sv
// c_regresivo_mmss -- MM:SS BCD countdown timer.
//
// Four BCD digits (min_d:min_u:seg_d:seg_u) count down one second per
// `tick` pulse while in RUN. A borrow ripples seg_u (mod 10) -> seg_d
// (mod 6) -> min_u (mod 10) -> min_d. Reaching 00:00 enters DONE and
// pulses `fin` for one cycle.
//
// All state updates happen on the falling edge of clk. `rst` is
// synchronous and active-high.
//
// Ports:
//   clk, rst                 clock (falling edge active), sync reset
//   tick                     1 Hz enable, one clk cycle wide
//   load                     copy carga_* (clamped) into the counter, go IDLE
//   start / stop             run / pause commands
//   carga_{min,seg}_{d,u}    preset digits
//   min_d, min_u, seg_d, seg_u  current digits
//   corriendo                registered state==RUN
//   fin                      one-cycle pulse on entering DONE
//   alarma                   held expiry flag
//
// Optional feature macro: REGRESIVO_ALARMA_EN
//   defined   -> alarma sets on entering DONE, cleared by load/rst or by a
//                start issued in DONE (acknowledge).
//   undefined -> alarma tied to 0.
module c_regresivo_mmss (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] carga_min_d,
  input  logic [3:0] carga_min_u,
  input  logic [3:0] carga_seg_d,
  input  logic [3:0] carga_seg_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] seg_d,
  output logic [3:0] seg_u,
  output logic       corriendo,
  output logic       fin,
  output logic       alarma
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] md_q, md_d, mu_q, mu_d, sd_q, sd_d, su_q, su_d;
  logic       corriendo_q, corriendo_d;
  logic       fin_q, fin_d;
  logic       alarma_q, alarma_d;

  // Decremented value, borrow chain from seconds units upward.
  logic [3:0] md_dec, mu_dec, sd_dec, su_dec;
  logic       b_su, b_sd, b_mu;
  logic       dec_zero, cur_zero;

  always_comb begin
    b_su   = (su_q == 4'd0);
    su_dec = b_su ? 4'd9 : su_q - 4'd1;
    b_sd   = b_su && (sd_q == 4'd0);
    sd_dec = b_su ? ((sd_q == 4'd0) ? 4'd5 : sd_q - 4'd1) : sd_q;
    b_mu   = b_sd && (mu_q == 4'd0);
    mu_dec = b_sd ? ((mu_q == 4'd0) ? 4'd9 : mu_q - 4'd1) : mu_q;
    // RUN guarantees a nonzero value, so min_d never underflows here.
    md_dec = b_mu ? md_q - 4'd1 : md_q;
    dec_zero = ({md_dec, mu_dec, sd_dec, su_dec} == 16'h0000);
    cur_zero = ({md_q, mu_q, sd_q, su_q} == 16'h0000);
  end

  always_comb begin
    state_d  = state_q;
    md_d     = md_q;
    mu_d     = mu_q;
    sd_d     = sd_q;
    su_d     = su_q;
    fin_d    = 1'b0;
    alarma_d = alarma_q;

    // Priority: load > stop > start > tick. A command that wins the edge
    // consumes it, so a coincident tick is never counted.
    if (load) begin
      md_d     = (carga_min_d > 4'd5) ? 4'd5 : carga_min_d;
      mu_d     = (carga_min_u > 4'd9) ? 4'd9 : carga_min_u;
      sd_d     = (carga_seg_d > 4'd5) ? 4'd5 : carga_seg_d;
      su_d     = (carga_seg_u > 4'd9) ? 4'd9 : carga_seg_u;
      state_d  = IDLE;
      alarma_d = 1'b0;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSE) && !cur_zero)
        state_d = RUN;
`ifdef REGRESIVO_ALARMA_EN
      else if (state_q == DONE && alarma_q)
        alarma_d = 1'b0;
`endif
    end else if (tick && state_q == RUN) begin
      md_d = md_dec;
      mu_d = mu_dec;
      sd_d = sd_dec;
      su_d = su_dec;
      if (dec_zero) begin
        state_d = DONE;
        fin_d   = 1'b1;
`ifdef REGRESIVO_ALARMA_EN
        alarma_d = 1'b1;
`endif
      end
    end

    corriendo_d = (state_d == RUN);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      md_q        <= 4'd0;
      mu_q        <= 4'd0;
      sd_q        <= 4'd0;
      su_q        <= 4'd0;
      corriendo_q <= 1'b0;
      fin_q       <= 1'b0;
      alarma_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_q        <= md_d;
      mu_q        <= mu_d;
      sd_q        <= sd_d;
      su_q        <= su_d;
      corriendo_q <= corriendo_d;
      fin_q       <= fin_d;
      alarma_q    <= alarma_d;
    end
  end

  assign min_d     = md_q;
  assign min_u     = mu_q;
  assign seg_d     = sd_q;
  assign seg_u     = su_q;
  assign corriendo = corriendo_q;
  assign fin       = fin_q;
`ifdef REGRESIVO_ALARMA_EN
  assign alarma    = alarma_q;
`else
  assign alarma    = 1'b0;
`endif

endmodule

// File: tb/tb_c_regresivo_mmss.sv
module tb_c_regresivo_mmss;

`ifdef REGRESIVO_ALARMA_EN
  localparam logic ALM = 1'b1;
`else
  localparam logic ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, load, start, stop;
  logic [3:0] carga_min_d, carga_min_u, carga_seg_d, carga_seg_u;
  logic [3:0] min_d, min_u, seg_d, seg_u;
  logic       corriendo, fin, alarma;

  c_regresivo_mmss dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start), .stop(stop),
    .carga_min_d(carga_min_d), .carga_min_u(carga_min_u),
    .carga_seg_d(carga_seg_d), .carga_seg_u(carga_seg_u),
    .min_d(min_d), .min_u(min_u), .seg_d(seg_d), .seg_u(seg_u),
    .corriendo(corriendo), .fin(fin), .alarma(alarma)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, ld, st, sp, tk;
    logic [15:0] carga;
    logic [15:0] e_dig;
    logic        e_run, e_fin, e_alm;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] dig;
    logic        run, fn, alm;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, ld, st, sp, tk, input logic [15:0] carga,
                              input logic [15:0] e_dig, input logic e_run, e_fin, e_alm,
                              input string name);
    vec_t v;
    v.r = r; v.ld = ld; v.st = st; v.sp = sp; v.tk = tk; v.carga = carga;
    v.e_dig = e_dig; v.e_run = e_run; v.e_fin = e_fin; v.e_alm = e_alm; v.name = name;
    vecs.push_back(v);
  endfunction

  // Inputs are driven just after a rising edge, sampled by the DUT on the
  // following falling edge, and outputs are checked at the next rising edge.
  task automatic apply(input vec_t v);
    exp_t e, g;
    logic [15:0] got;
    rst = v.r; load = v.ld; start = v.st; stop = v.sp; tick = v.tk;
    {carga_min_d, carga_min_u, carga_seg_d, carga_seg_u} = v.carga;
    e.dig = v.e_dig; e.run = v.e_run; e.fn = v.e_fin; e.alm = v.e_alm; e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    g = sb.pop_front();
    got = {min_d, min_u, seg_d, seg_u};
    n_cmp++;
    if (got !== g.dig || corriendo !== g.run || fin !== g.fn || alarma !== g.alm) begin
      n_bad++;
      $display("FAIL %s: got dig=%h run=%b fin=%b alm=%b, want dig=%h run=%b fin=%b alm=%b",
               g.name, got, corriendo, fin, alarma, g.dig, g.run, g.fn, g.alm);
    end
  endtask

  task automatic step(input logic r, ld, st, sp, tk, input logic [15:0] carga,
                      input logic [15:0] e_dig, input logic e_run, e_fin, e_alm,
                      input string name);
    vec_t v;
    v.r = r; v.ld = ld; v.st = st; v.sp = sp; v.tk = tk; v.carga = carga;
    v.e_dig = e_dig; v.e_run = e_run; v.e_fin = e_fin; v.e_alm = e_alm; v.name = name;
    apply(v);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    {carga_min_d, carga_min_u, carga_seg_d, carga_seg_u} = 16'h0000;

    //  r ld st sp tk carga     exp dig  run fin alm
    add(1,0,0,0,0, 16'h0000, 16'h0000, 0,0,0,   "reset");
    // 00:03 down to expiry
    add(0,1,0,0,0, 16'h0003, 16'h0003, 0,0,0,   "load_0003");
    add(0,0,1,0,0, 16'h0000, 16'h0003, 1,0,0,   "start_0003");
    add(0,0,0,0,1, 16'h0000, 16'h0002, 1,0,0,   "tick_0002");
    add(0,0,0,0,1, 16'h0000, 16'h0001, 1,0,0,   "tick_0001");
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,ALM, "expire_fin");
    add(0,0,0,0,0, 16'h0000, 16'h0000, 0,0,ALM, "fin_one_cycle");
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,0,ALM, "done_tick_hold");
    add(0,0,1,0,0, 16'h0000, 16'h0000, 0,0,0,   "done_start_ack");
    add(0,0,1,0,1, 16'h0000, 16'h0000, 0,0,0,   "done_start_again");
    // full borrow chain
    add(0,1,0,0,0, 16'h1000, 16'h1000, 0,0,0,   "load_1000");
    add(0,0,1,0,0, 16'h0000, 16'h1000, 1,0,0,   "start_1000");
    add(0,0,0,0,1, 16'h0000, 16'h0959, 1,0,0,   "borrow_0959");
    add(0,0,0,0,0, 16'h0000, 16'h0959, 1,0,0,   "run_hold");
    // clamping
    add(0,1,0,0,0, 16'h7C9F, 16'h5959, 0,0,0,   "load_clamp");
    add(0,0,1,0,0, 16'h0000, 16'h5959, 1,0,0,   "start_5959");
    add(0,0,0,0,1, 16'h0000, 16'h5958, 1,0,0,   "tick_5958");
    // stop beats tick, pause ignores ticks, resume
    add(0,1,0,0,0, 16'h0005, 16'h0005, 0,0,0,   "load_0005");
    add(0,0,1,0,0, 16'h0000, 16'h0005, 1,0,0,   "start_0005");
    add(0,0,0,1,1, 16'h0000, 16'h0005, 0,0,0,   "stop_with_tick");
    add(0,0,0,0,1, 16'h0000, 16'h0005, 0,0,0,   "pause_tick_ignored");
    add(0,0,1,0,0, 16'h0000, 16'h0005, 1,0,0,   "resume");
    add(0,0,0,0,1, 16'h0000, 16'h0004, 1,0,0,   "resume_tick_0004");
    // start at 00:00 ignored
    add(0,1,0,0,0, 16'h0000, 16'h0000, 0,0,0,   "load_0000");
    add(0,0,1,0,0, 16'h0000, 16'h0000, 0,0,0,   "start_zero_ignored");
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,0,0,   "idle_tick_ignored");
    // start coincident with tick: tick not counted
    add(0,1,0,0,0, 16'h0002, 16'h0002, 0,0,0,   "load_0002");
    add(0,0,1,0,1, 16'h0000, 16'h0002, 1,0,0,   "start_with_tick");
    add(0,0,0,0,1, 16'h0000, 16'h0001, 1,0,0,   "first_tick_0001");
    // load beats tick mid-run
    add(0,1,0,0,1, 16'h0030, 16'h0030, 0,0,0,   "load_with_tick");
    add(0,0,1,0,0, 16'h0000, 16'h0030, 1,0,0,   "start_0030");
    add(0,0,0,0,1, 16'h0000, 16'h0029, 1,0,0,   "tick_0029");
    // reset mid-run
    add(1,0,0,0,1, 16'h0000, 16'h0000, 0,0,0,   "rst_mid_run");
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,0,0,   "after_rst_idle");

    @(posedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Expiry from 00:01, alarm held for 100 cycles, then acknowledge.
    step(0,1,0,0,0, 16'h0001, 16'h0001, 0,0,0,   "alm_load_0001");
    step(0,0,1,0,0, 16'h0000, 16'h0001, 1,0,0,   "alm_start");
    step(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,ALM, "alm_expire");
    for (int k = 0; k < 100; k++)
      step(0,0,0,0,(k % 7 == 0), 16'h0000, 16'h0000, 0,0,ALM, "alm_hold");
    step(0,0,1,0,0, 16'h0000, 16'h0000, 0,0,0,   "alm_ack");
    step(0,1,0,0,0, 16'h0100, 16'h0100, 0,0,0,   "alm_load_0100");
    // alarm cleared by load directly out of DONE
    step(0,0,1,0,0, 16'h0000, 16'h0100, 1,0,0,   "run_0100");
    step(0,0,0,0,1, 16'h0000, 16'h0059, 1,0,0,   "tick_0059");
    step(0,1,0,0,0, 16'h0001, 16'h0001, 0,0,0,   "reload_0001");
    step(0,0,1,0,0, 16'h0000, 16'h0001, 1,0,0,   "restart_0001");
    step(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,ALM, "expire_again");
    step(0,1,0,0,0, 16'h0203, 16'h0203, 0,0,0,   "load_clears_alarm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c_regresivo_mmss.md
# c_regresivo_mmss

Countdown timer for the clock design in MM:SS format, the decrementing counterpart of the up-counting time chain. It holds four BCD digits (minutes tens/units, seconds tens/units) and decrements once per `tick` enable pulse while running. A borrow ripples through mod-10 and mod-6 digit stages. On reaching 00:00 it pulses `fin`, and optionally raises a held alarm flag.

## Interface
Parameters: none.

- `clk` input 1 — system clock; all state updates on the falling edge.
- `rst` input 1 — reset; synchronous and active-high.
- `tick` input 1 — 1 Hz enable, one `clk` cycle wide.
- `load` input 1 — copy the `carga_*` digits into the counter.
- `start` input 1 — begin or resume the countdown.
- `stop` input 1 — pause the countdown.
- `carga_min_d` input 4 — preset minutes tens; valid 0–5.
- `carga_min_u` input 4 — preset minutes units; valid 0–9.
- `carga_seg_d` input 4 — preset seconds tens; valid 0–5.
- `carga_seg_u` input 4 — preset seconds units; valid 0–9.
- `min_d`, `min_u`, `seg_d`, `seg_u` output 4 each — current BCD digits.
- `corriendo` output 1 — high while in state RUN.
- `fin` output 1 — one-cycle pulse on reaching 00:00.
- `alarma` output 1 — held flag after expiry (see Configuration).

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - DONE
- Reset: all digits 0, state IDLE, `corriendo`=0, `fin`=0, `alarma`=0.
- Command priority per edge: `rst` > `load` > `stop` > `start` > `tick`.
- `load`, from any state:
  - Digits take the `carga_*` values, with out-of-range digits clamped: units >9 → 9, tens >5 → 5.
  - State goes to IDLE; `alarma` clears.
- `start`, in IDLE or PAUSE:
  - Nonzero value → RUN.
  - Value 00:00 → `start` ignored.
  - In RUN or DONE, `start` is ignored.
- `stop`: RUN → PAUSE; ignored in all other states.
- `tick` in RUN decrements by one second:
  - `seg_u` 0 → 9 with borrow, else `seg_u`−1.
  - On a borrow, `seg_d` 0 → 5 with borrow, else `seg_d`−1.
  - On a borrow, `min_u` 0 → 9 with borrow, else `min_u`−1.
  - On a borrow, `min_d` decrements (cannot underflow, since the counter is nonzero in RUN).
- `tick` is ignored in IDLE, PAUSE and DONE.
- Expiry: a RUN `tick` that produces 00:00 moves the state to DONE on the same edge.
- DONE:
  - Digits hold at 00:00.
  - Exits only via `load` or `rst`.
- `corriendo` is a registered decode of state==RUN.

## Timing
- Digit outputs are registered and change on the falling `clk` edge where `tick` (in RUN) or `load` is sampled.
- Zero added latency.
- `fin` is registered:
  - High for exactly one cycle, the cycle beginning at the edge that enters DONE.
  - Never re-asserts while in DONE.
- `stop` and `tick` on the same edge: `stop` wins; no decrement occurs.
- `load` and `tick` on the same edge: the loaded value wins; no decrement is applied.
- `rst` mid-count: digits return to 00:00 on that edge; `fin` is not pulsed.
- `start` sampled on the same edge as a `tick`: that `tick` is not counted. The first decrement occurs on the next `tick`.

## Configuration
- Macro `REGRESIVO_ALARMA_EN`.
- Defined:
  - `alarma` sets on the edge entering DONE and stays high until `load` or `rst`.
  - While `alarma` is high, a `start` in DONE acknowledges it: `alarma` clears and the state stays DONE.
- Undefined: `alarma` is tied to 0, and the acknowledge logic is absent.
- `fin` behaviour is identical in both builds.

## Test plan
- Load 00:03, pulse `start`, apply 3 ticks:
  - Digits go 00:02, 00:01, 00:00.
  - `fin` is high for one cycle after the 3rd tick; state DONE, `corriendo`=0.
- Load 10:00, run, apply 1 tick:
  - Digits become 09:59; full borrow chain.
  - `corriendo`=1 throughout.
- Load digits {7,12,9,15}:
  - Outputs read 5,9,5,9 (clamped).
  - `start` then tick gives 59:58.
- Load 00:05, run, assert `stop` with a coincident `tick`:
  - Value stays 00:05, state PAUSE, further ticks are ignored.
  - `start` resumes, and the next tick gives 00:04.
- Load 00:00, pulse `start`: state stays IDLE, `corriendo`=0, `fin` never asserts.
- With `REGRESIVO_ALARMA_EN`:
  - Expire from 00:01: `alarma`=1 and holds for 100 cycles.
  - `start` clears it; a later `load` 01:00 leaves `alarma`=0.
  - Apply `rst` mid-run: all outputs 0 on the next edge.
